// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending controller: the controller state
// enumeration, the default currency width and the slot-index width.
// No ports (package).
// ---------------------------------------------------------------------------
package vend_pkg;

    localparam int CURRENCY_WIDTH_DEF = 7;
    localparam int IDX_W              = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        VEND    = 3'd2,
        CHANGE  = 3'd3,
        REFUND  = 3'd4,
        DONE    = 3'd5
    } vend_state_e;

endpackage

// File: rtl/vend_item_table.sv
// ---------------------------------------------------------------------------
// vend_item_table
// Per-slot price and 4-bit stock storage.
//   clk, rst           : clock, synchronous active-high reset (clears table)
//   wr_en_i/wr_idx_i   : write strobe and slot; wr_price_i/wr_stock_i data
//   rd_idx_i           : combinational read slot; rd_price_o/rd_stock_o data
//   dec_en_i/dec_idx_i : decrement the stock of one slot by one
// Slots at or beyond NUM_ITEMS do not exist: writes to them are dropped and
// reads of them return price 0 / stock 0, so they always look sold out.
// ---------------------------------------------------------------------------
module vend_item_table
    import vend_pkg::*;
#(
    parameter int CURRENCY_WIDTH = CURRENCY_WIDTH_DEF,
    parameter int NUM_ITEMS      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en_i,
    input  logic [IDX_W-1:0]          wr_idx_i,
    input  logic [CURRENCY_WIDTH-1:0] wr_price_i,
    input  logic [3:0]                wr_stock_i,
    input  logic [IDX_W-1:0]          rd_idx_i,
    output logic [CURRENCY_WIDTH-1:0] rd_price_o,
    output logic [3:0]                rd_stock_o,
    input  logic                      dec_en_i,
    input  logic [IDX_W-1:0]          dec_idx_i
);

    logic [CURRENCY_WIDTH-1:0] price_q [NUM_ITEMS];
    logic [3:0]                stock_q [NUM_ITEMS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                price_q[i] <= '0;
                stock_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
                    price_q[i] <= wr_price_i;
                    stock_q[i] <= wr_stock_i;
                end else if (dec_en_i && (dec_idx_i == IDX_W'(i)) && (stock_q[i] != 4'd0)) begin
                    stock_q[i] <= stock_q[i] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        rd_price_o = '0;
        rd_stock_o = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                rd_price_o = price_q[i];
                rd_stock_o = stock_q[i];
            end
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// ---------------------------------------------------------------------------
// vend_ctrl
// Vending machine transaction controller: selection, coin collection with
// idle timeout, vend handshake, change/refund handshake and accumulator clear.
//   clk, rst                  : clock, synchronous active-high reset
//   total_currency            : running coin total from the accumulator
//   cfg_wr/cfg_idx/cfg_price/cfg_stock : slot configuration (IDLE only)
//   sel_valid/sel_idx         : customer selection
//   cancel                    : customer cancel (COLLECT only)
//   vend_valid/vend_item/vend_ready       : vend handshake
//   change_valid/change_value/change_ready: change/refund handshake
//   dispense_valid            : held until the accumulator reads zero
//   sold_out                  : one-cycle rejection pulse
//   busy                      : transaction in progress
// ---------------------------------------------------------------------------
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int CURRENCY_WIDTH = CURRENCY_WIDTH_DEF,
    parameter int NUM_ITEMS      = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CURRENCY_WIDTH-1:0] total_currency,
    input  logic                      cfg_wr,
    input  logic [IDX_W-1:0]          cfg_idx,
    input  logic [CURRENCY_WIDTH-1:0] cfg_price,
    input  logic [3:0]                cfg_stock,
    input  logic                      sel_valid,
    input  logic [IDX_W-1:0]          sel_idx,
    input  logic                      cancel,
    input  logic                      vend_ready,
    input  logic                      change_ready,
    output logic                      vend_valid,
    output logic [IDX_W-1:0]          vend_item,
    output logic                      change_valid,
    output logic [CURRENCY_WIDTH-1:0] change_value,
    output logic                      dispense_valid,
    output logic                      sold_out,
    output logic                      busy
);

    localparam int              TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    vend_state_e               state_q, state_d;
    logic [IDX_W-1:0]          sel_q, sel_d;
    logic [CURRENCY_WIDTH-1:0] price_q, price_d;
    logic [CURRENCY_WIDTH-1:0] change_q, change_d;
    logic [CURRENCY_WIDTH-1:0] prev_total_q;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic                      sold_out_q, sold_out_d;

    logic [CURRENCY_WIDTH-1:0] tbl_price;
    logic [3:0]                tbl_stock;
    logic                      dec_en;

    vend_item_table #(
        .CURRENCY_WIDTH (CURRENCY_WIDTH),
        .NUM_ITEMS      (NUM_ITEMS)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (cfg_wr && (state_q == IDLE)),
        .wr_idx_i   (cfg_idx),
        .wr_price_i (cfg_price),
        .wr_stock_i (cfg_stock),
        .rd_idx_i   (sel_idx),
        .rd_price_o (tbl_price),
        .rd_stock_o (tbl_stock),
        .dec_en_i   (dec_en),
        .dec_idx_i  (sel_q)
    );

    // Control state is reset; the latched selection, price, change amount and
    // previous total are plain data, masked at the outputs outside their states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            sold_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            sold_out_q <= sold_out_d;
        end
        sel_q        <= sel_d;
        price_q      <= price_d;
        change_q     <= change_d;
        prev_total_q <= total_currency;
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        price_d    = price_q;
        change_d   = change_q;
        tmo_d      = tmo_q;
        sold_out_d = 1'b0;
        dec_en     = 1'b0;

        case (state_q)
            IDLE: begin
                // Out-of-range slots read back stock 0, so one test covers both rejections.
                if (sel_valid) begin
                    if (tbl_stock != 4'd0) begin
                        sel_d   = sel_idx;
                        price_d = tbl_price;
                        tmo_d   = '0;
                        state_d = COLLECT;
                    end else begin
                        sold_out_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (total_currency != prev_total_q) begin
                    tmo_d = '0;
                end else if (tmo_q != TMO_LAST) begin
                    tmo_d = tmo_q + TW'(1);
                end
                // Sufficient payment wins over cancel/timeout in the same cycle.
                if (total_currency >= price_q) begin
                    state_d = VEND;
                end else if (cancel || (tmo_q == TMO_LAST)) begin
                    state_d = REFUND;
                end
            end
            VEND: begin
                if (vend_ready) begin
                    dec_en   = 1'b1;
                    change_d = total_currency - price_q;
                    state_d  = (total_currency != price_q) ? CHANGE : DONE;
                end
            end
            REFUND: begin
                // One-cycle state: captures the refund amount so it stays stable in CHANGE.
                if (total_currency == '0) begin
                    state_d = DONE;
                end else begin
                    change_d = total_currency;
                    state_d  = CHANGE;
                end
            end
            CHANGE: begin
                if (change_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (total_currency == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vend_valid     = (state_q == VEND);
    assign vend_item      = vend_valid ? sel_q : '0;
    assign change_valid   = (state_q == CHANGE);
    assign change_value   = change_valid ? change_q : '0;
    assign dispense_valid = (state_q == DONE);
    assign sold_out       = sold_out_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_vend_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_ctrl
// Bench for vend_ctrl: directed purchase scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level
// model of the vending rules.
// ---------------------------------------------------------------------------
module tb_vend_ctrl;

    localparam int CW = 7;
    localparam int N  = 4;
    localparam int T  = 8;

    // model phases
    localparam int PH_IDLE    = 0;
    localparam int PH_COLLECT = 1;
    localparam int PH_VEND    = 2;
    localparam int PH_CHANGE  = 3;
    localparam int PH_REFUND  = 4;
    localparam int PH_DONE    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] total_currency;
    logic          cfg_wr;
    logic [3:0]    cfg_idx;
    logic [CW-1:0] cfg_price;
    logic [3:0]    cfg_stock;
    logic          sel_valid;
    logic [3:0]    sel_idx;
    logic          cancel;
    logic          vend_ready;
    logic          change_ready;
    logic          vend_valid;
    logic [3:0]    vend_item;
    logic          change_valid;
    logic [CW-1:0] change_value;
    logic          dispense_valid;
    logic          sold_out;
    logic          busy;

    vend_ctrl #(
        .CURRENCY_WIDTH (CW),
        .NUM_ITEMS      (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .total_currency (total_currency),
        .cfg_wr         (cfg_wr),
        .cfg_idx        (cfg_idx),
        .cfg_price      (cfg_price),
        .cfg_stock      (cfg_stock),
        .sel_valid      (sel_valid),
        .sel_idx        (sel_idx),
        .cancel         (cancel),
        .vend_ready     (vend_ready),
        .change_ready   (change_ready),
        .vend_valid     (vend_valid),
        .vend_item      (vend_item),
        .change_valid   (change_valid),
        .change_value   (change_value),
        .dispense_valid (dispense_valid),
        .sold_out       (sold_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_print = 0;
    bit chk_en  = 1'b0;

    // Behavioural model state
    int m_price [16];
    int m_stock [16];
    int m_phase = PH_IDLE;
    int m_sel   = 0;
    int m_cost  = 0;
    int m_still = 0;   // consecutive COLLECT cycles with an unchanged total
    int m_chg   = 0;
    int m_sold  = 0;
    int m_prev  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
            end
        end
    endtask

    task automatic model_tick();
        int t;
        int s;
        t = int'(total_currency);
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_price[i] = 0;
                m_stock[i] = 0;
            end
            m_phase = PH_IDLE;
            m_still = 0;
            m_sold  = 0;
            m_prev  = t;
            chk_en  = 1'b1;
            return;
        end
        m_sold = 0;
        case (m_phase)
            PH_IDLE: begin
                s = int'(sel_idx);
                if (sel_valid) begin
                    if (s < N && m_stock[s] > 0) begin
                        m_sel   = s;
                        m_cost  = m_price[s];
                        m_still = 0;
                        m_phase = PH_COLLECT;
                    end else begin
                        m_sold = 1;
                    end
                end
                if (cfg_wr && int'(cfg_idx) < N) begin
                    m_price[int'(cfg_idx)] = int'(cfg_price);
                    m_stock[int'(cfg_idx)] = int'(cfg_stock);
                end
            end
            PH_COLLECT: begin
                if (t >= m_cost)                    m_phase = PH_VEND;
                else if (cancel || m_still == T-1)  m_phase = PH_REFUND;
                if (t != m_prev)                    m_still = 0;
                else if (m_still < T-1)             m_still = m_still + 1;
            end
            PH_VEND: begin
                if (vend_ready) begin
                    m_stock[m_sel] = m_stock[m_sel] - 1;
                    m_chg   = (t - m_cost) % (1 << CW);
                    m_phase = (m_chg != 0) ? PH_CHANGE : PH_DONE;
                end
            end
            PH_REFUND: begin
                if (t == 0) m_phase = PH_DONE;
                else begin
                    m_chg   = t;
                    m_phase = PH_CHANGE;
                end
            end
            PH_CHANGE: if (change_ready) m_phase = PH_DONE;
            PH_DONE:   if (t == 0)       m_phase = PH_IDLE;
            default:   m_phase = PH_IDLE;
        endcase
        m_prev = t;
    endtask

    task automatic cmp_all();
        chk("vend_valid",     int'(vend_valid),     (m_phase == PH_VEND) ? 1 : 0);
        chk("vend_item",      int'(vend_item),      (m_phase == PH_VEND) ? m_sel : 0);
        chk("change_valid",   int'(change_valid),   (m_phase == PH_CHANGE) ? 1 : 0);
        chk("change_value",   int'(change_value),   (m_phase == PH_CHANGE) ? m_chg : 0);
        chk("dispense_valid", int'(dispense_valid), (m_phase == PH_DONE) ? 1 : 0);
        chk("sold_out",       int'(sold_out),       m_sold);
        chk("busy",           int'(busy),           (m_phase != PH_IDLE) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        if (chk_en) cmp_all();
        #1;
    endtask

    task automatic cfg(input int idx, input int price, input int stock);
        cfg_wr    = 1'b1;
        cfg_idx   = 4'(idx);
        cfg_price = CW'(price);
        cfg_stock = 4'(stock);
        step();
        cfg_wr    = 1'b0;
    endtask

    task automatic select(input int idx);
        sel_valid = 1'b1;
        sel_idx   = 4'(idx);
        step();
        sel_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; total_currency = '0; cfg_wr = 1'b0; cfg_idx = '0; cfg_price = '0;
        cfg_stock = '0; sel_valid = 1'b0; sel_idx = '0; cancel = 1'b0;
        vend_ready = 1'b0; change_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_vend", int'(vend_valid), 0);
        chk("rst_disp", int'(dispense_valid), 0);

        cfg(1, 25, 2);
        cfg(0, 30, 1);
        cfg(2, 5, 0);
        cfg(3, 40, 3);

        // exact payment on slot 1
        select(1);
        chk("exact_busy", int'(busy), 1);
        total_currency = 7'd10; step();
        total_currency = 7'd25; vend_ready = 1'b1; step();
        chk("exact_vv", int'(vend_valid), 1);
        chk("exact_item", int'(vend_item), 1);
        step();
        chk("exact_vv_off", int'(vend_valid), 0);
        chk("exact_noch", int'(change_valid), 0);
        chk("exact_disp", int'(dispense_valid), 1);
        step();
        chk("exact_disp2", int'(dispense_valid), 1);
        total_currency = '0; vend_ready = 1'b0; step();
        chk("exact_idle", int'(busy), 0);

        // cancel with nothing inserted
        select(1);
        cancel = 1'b1; step(); cancel = 1'b0;
        step();
        chk("cancel0_disp", int'(dispense_valid), 1);
        chk("cancel0_noch", int'(change_valid), 0);
        step();
        chk("cancel0_idle", int'(busy), 0);

        // overpay on slot 0 with a slow mechanism
        select(0);
        total_currency = 7'd50; step();
        for (int i = 0; i < 4; i++) begin
            chk("ovp_vv", int'(vend_valid), 1);
            vend_ready = (i == 3);
            step();
        end
        vend_ready = 1'b0;
        chk("ovp_vv_off", int'(vend_valid), 0);
        for (int i = 0; i < 3; i++) begin
            chk("ovp_cv", int'(change_valid), 1);
            chk("ovp_val", int'(change_value), 20);
            change_ready = (i == 2);
            step();
        end
        change_ready = 1'b0;
        chk("ovp_cv_off", int'(change_valid), 0);
        total_currency = '0; step();

        // sold out: empty slot, then a slot that does not exist
        select(2);
        chk("so_pulse", int'(sold_out), 1);
        chk("so_busy", int'(busy), 0);
        step();
        chk("so_end", int'(sold_out), 0);
        select(5);
        chk("so_range", int'(sold_out), 1);
        step();

        // second sale of slot 1 empties it
        select(1);
        total_currency = 7'd25; vend_ready = 1'b1; step();
        step();
        total_currency = '0; vend_ready = 1'b0; step();
        select(1);
        chk("so_emptied", int'(sold_out), 1);
        step();

        // idle timeout with coins in
        total_currency = 7'd10; step();
        select(3);
        for (int i = 0; i < T; i++) begin
            chk("tmo_wait", int'(busy), 1);
            step();
        end
        chk("tmo_refund_cv", int'(change_valid), 0);
        step();
        chk("tmo_cv", int'(change_valid), 1);
        chk("tmo_val", int'(change_value), 10);
        change_ready = 1'b1; step(); change_ready = 1'b0;
        total_currency = '0; step();

        // reset while vending
        select(3);
        total_currency = 7'd40; step();
        chk("rv_vv", int'(vend_valid), 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rv_vv_off", int'(vend_valid), 0);
        chk("rv_item", int'(vend_item), 0);
        chk("rv_busy", int'(busy), 0);
        chk("rv_disp", int'(dispense_valid), 0);
        total_currency = '0;
        select(3);
        chk("rv_stock_clr", int'(sold_out), 1);
        step();

        // restock and run random traffic
        cfg(0, 20, 3); cfg(1, 35, 3); cfg(2, 7, 2); cfg(3, 50, 3);
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 299) == 0);
            cfg_wr       = ($urandom_range(0, 7) == 0);
            cfg_idx      = 4'($urandom_range(0, 5));
            cfg_price    = CW'($urandom_range(1, 60));
            cfg_stock    = 4'($urandom_range(0, 3));
            sel_valid    = ($urandom_range(0, 3) == 0);
            sel_idx      = 4'($urandom_range(0, 5));
            cancel       = ($urandom_range(0, 15) == 0);
            vend_ready   = 1'($urandom_range(0, 1));
            change_ready = 1'($urandom_range(0, 1));
            if (dispense_valid && $urandom_range(0, 1) == 1)
                total_currency = '0;
            else if ($urandom_range(0, 3) == 0 && total_currency < 7'd100)
                total_currency = total_currency + CW'($urandom_range(1, 20));
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter CURRENCY_WIDTH, default 7, setting the width of all currency values.
REQ-002 SHALL have parameter NUM_ITEMS, default 4, range 2..16, setting the number of product slots.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, setting the idle cycles in COLLECT before refund.
REQ-004 SHALL have ports:
 clk  in  1  clock; all logic on posedge.
 rst  in  1  reset; synchronous, active-high.
 total_currency  in  CURRENCY_WIDTH  running sum from the currency accumulator.
 cfg_wr  in  1  price/stock write strobe.
 cfg_idx  in  4  slot index for the write.
 cfg_price  in  CURRENCY_WIDTH  price to write.
 cfg_stock  in  4  stock count to write.
 sel_valid  in  1  customer selection strobe.
 sel_idx  in  4  selected slot.
 cancel  in  1  customer cancel request.
 vend_ready  in  1  mechanism accepts the vend.
 change_ready  in  1  coin return accepts the change.
 vend_valid  out  1  vend request.
 vend_item  out  4  slot being vended.
 change_valid  out  1  change/refund request.
 change_value  out  CURRENCY_WIDTH  amount to return.
 dispense_valid  out  1  clears the accumulator.
 sold_out  out  1  one-cycle rejection pulse.
 busy  out  1  high when state != IDLE.

Function
REQ-005 SHALL use FSM states IDLE, COLLECT, VEND, CHANGE, REFUND, DONE.
REQ-006 SHALL keep per-slot price and 4-bit stock registers; a cfg_wr with cfg_idx < NUM_ITEMS SHALL write them only in IDLE; in any other state, or with an out-of-range cfg_idx, the write SHALL be ignored.
REQ-007 IDLE: sel_valid with sel_idx < NUM_ITEMS and stock > 0 SHALL latch sel_idx and the slot price, then enter COLLECT next cycle.
REQ-008 IDLE: sel_valid with stock == 0 or sel_idx out of range SHALL pulse sold_out for 1 cycle and stay in IDLE.
REQ-009 COLLECT: total_currency >= latched price SHALL enter VEND next cycle; this check SHALL take priority over cancel and timeout in the same cycle.
REQ-010 COLLECT: cancel, or the timeout counter reaching TIMEOUT_CYCLES-1, SHALL enter REFUND.
REQ-011 The timeout counter SHALL clear on COLLECT entry and whenever total_currency differs from its value in the previous cycle; otherwise it SHALL increment, saturating at TIMEOUT_CYCLES-1.
REQ-012 VEND: vend_valid SHALL be held high with vend_item stable until vend_ready is sampled high (valid/ready handshake); cancel SHALL be ignored in VEND.
REQ-013 On the VEND handshake cycle, the controller SHALL decrement the slot stock, register change_value = total_currency - price (unsigned, CURRENCY_WIDTH bits, never negative by REQ-009), and enter CHANGE if the difference is nonzero, otherwise DONE.
REQ-014 REFUND: if total_currency == 0, SHALL go directly to DONE; otherwise SHALL set change_value = total_currency and proceed as in CHANGE.
REQ-015 CHANGE/REFUND: change_valid SHALL be held high with change_value stable until change_ready is sampled high, then enter DONE.
REQ-016 DONE: dispense_valid SHALL be held high until total_currency == 0 is sampled, then the FSM SHALL return to IDLE; coins that arrive during DONE are discarded.
REQ-017 sel_valid outside IDLE SHALL be ignored and SHALL NOT pulse sold_out.

Reset
REQ-018 With rst high at a clk edge, the state SHALL become IDLE and all outputs SHALL be 0 (vend_valid, vend_item, change_valid, change_value, dispense_valid, sold_out, busy), including when reset occurs mid-transaction.
REQ-019 Reset SHALL clear all prices and stock to 0 and clear the timeout counter.

Structure
REQ-020 A shared package SHALL hold the state enumeration, the default CURRENCY_WIDTH, and the item-index width constant (4).
REQ-021 The price/stock table SHALL be a sub-module, vend_item_table, with a write port, a read port, and a decrement port.

Verification
REQ-022 Exact payment: price[1]=25, stock[1]=2, select 1, total rises to 25, vend_ready=1 -> vend_item=1 pulse, no change_valid, dispense_valid until total=0, stock[1]=1.
REQ-023 Overpay: price[0]=30, total=50, vend_ready delayed 3 cycles -> vend_valid held 4 cycles, then change_value=20, change_valid held until change_ready.
REQ-024 Sold out: stock[2]=0, select 2 -> sold_out high for exactly 1 cycle, busy stays 0.
REQ-025 Timeout: TIMEOUT_CYCLES=8, total=10 steady after selection -> REFUND with change_value=10 on the 8th unchanged cycle; cancel with total=0 -> DONE without change_valid.
REQ-026 Reset mid-VEND: rst high while vend_valid=1 -> next cycle all outputs 0, state IDLE, stock cleared.
